// File: rtl/drop_sequencer.sv
// drop_sequencer: registered temperature-compare / drop sequencer with a
// four-digit seven-segment status display.
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   t_act, t_lim      - actual and limit temperature, unsigned, W bits
//   drop_en           - level enable for the drop actuator
//   drop_activated    - actuator drive, high only in DROP
//   drop_count        - number of drops started, saturating at 255
//   busy              - high in DROP or HOLDOFF
//   seven_seg1..4     - digits left to right, bit0 = segment a, active-high
module drop_sequencer #(
  parameter int unsigned W              = 16,
  parameter int unsigned HYST           = 2,
  parameter int unsigned DROP_CYCLES    = 8,
  parameter int unsigned HOLDOFF_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] t_act,
  input  logic [W-1:0] t_lim,
  input  logic         drop_en,
  output logic         drop_activated,
  output logic [7:0]   drop_count,
  output logic         busy,
  output logic [6:0]   seven_seg1,
  output logic [6:0]   seven_seg2,
  output logic [6:0]   seven_seg3,
  output logic [6:0]   seven_seg4
);

  localparam int unsigned MaxCycles =
      (DROP_CYCLES > HOLDOFF_CYCLES) ? DROP_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] DropLoad    = CntW'(DROP_CYCLES - 1);
  localparam logic [CntW-1:0] HoldoffLoad = CntW'(HOLDOFF_CYCLES - 1);

  // Status words, digit 1 in the top 7 bits.
  localparam logic [27:0] WordBlank = 28'h0;
  localparam logic [27:0] WordCold  = {7'h39, 7'h5C, 7'h38, 7'h5E};
  localparam logic [27:0] WordHot   = {7'h00, 7'h76, 7'h5C, 7'h78};
  localparam logic [27:0] WordDrop  = {7'h5E, 7'h50, 7'h5C, 7'h73};
  localparam logic [27:0] WordDash  = {7'h40, 7'h40, 7'h40, 7'h40};

  typedef enum logic [2:0] {
    StIdle,
    StCold,
    StHot,
    StDrop,
    StHoldoff
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      drop_count_q, drop_count_d;
  logic            drop_activated_q, drop_activated_d;
  logic            busy_q, busy_d;
  logic [27:0]     seg_q, seg_d;

  // One extra bit so t_act + HYST cannot wrap.
  logic [W:0] act_ext, lim_ext;
  logic       below;

  assign act_ext = {1'b0, t_act};
  assign lim_ext = {1'b0, t_lim};
  assign below   = (act_ext + (W+1)'(HYST)) < lim_ext;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drop_count_d = drop_count_q;

    unique case (state_q)
      StIdle, StCold, StHot: begin
        if (drop_en && below) begin
          state_d = StDrop;
          cnt_d   = DropLoad;
          if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end else if (drop_en) begin
          state_d = StHot;
        end else if (t_act < t_lim) begin
          state_d = StCold;
        end else begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        // Releasing drop_en aborts straight into the hold-off window.
        if (!drop_en || (cnt_q == '0)) begin
          state_d = StHoldoff;
          cnt_d   = HoldoffLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHoldoff: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the next state so they move on the same edge.
  always_comb begin
    drop_activated_d = 1'b0;
    busy_d           = 1'b0;
    seg_d            = WordBlank;
    unique case (state_d)
      StIdle:    seg_d = WordBlank;
      StCold:    seg_d = WordCold;
      StHot:     seg_d = WordHot;
      StDrop: begin
        seg_d            = WordDrop;
        drop_activated_d = 1'b1;
        busy_d           = 1'b1;
      end
      StHoldoff: begin
        seg_d  = WordDash;
        busy_d = 1'b1;
      end
      default:   seg_d = WordBlank;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      drop_count_q     <= '0;
      drop_activated_q <= 1'b0;
      busy_q           <= 1'b0;
      seg_q            <= WordBlank;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      drop_count_q     <= drop_count_d;
      drop_activated_q <= drop_activated_d;
      busy_q           <= busy_d;
      seg_q            <= seg_d;
    end
  end

  assign drop_activated = drop_activated_q;
  assign drop_count     = drop_count_q;
  assign busy           = busy_q;
  assign seven_seg1     = seg_q[27:21];
  assign seven_seg2     = seg_q[20:14];
  assign seven_seg3     = seg_q[13:7];
  assign seven_seg4     = seg_q[6:0];

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer with DROP_CYCLES=4, HOLDOFF_CYCLES=3.
module tb_drop_sequencer;

  localparam logic [27:0] Blank = 28'h0;
  localparam logic [27:0] Cold  = {7'h39, 7'h5C, 7'h38, 7'h5E};
  localparam logic [27:0] Hot   = {7'h00, 7'h76, 7'h5C, 7'h78};
  localparam logic [27:0] Drop  = {7'h5E, 7'h50, 7'h5C, 7'h73};
  localparam logic [27:0] Dash  = {7'h40, 7'h40, 7'h40, 7'h40};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] t_act = '0;
  logic [15:0] t_lim = '0;
  logic        drop_en = 1'b0;
  logic        drop_activated;
  logic [7:0]  drop_count;
  logic        busy;
  logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;
  logic [27:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

  assign seg = {seven_seg1, seven_seg2, seven_seg3, seven_seg4};

  always #5 clk = ~clk;

  drop_sequencer #(
    .W              (16),
    .HYST           (2),
    .DROP_CYCLES    (4),
    .HOLDOFF_CYCLES (3)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .t_act          (t_act),
    .t_lim          (t_lim),
    .drop_en        (drop_en),
    .drop_activated (drop_activated),
    .drop_count     (drop_count),
    .busy           (busy),
    .seven_seg1     (seven_seg1),
    .seven_seg2     (seven_seg2),
    .seven_seg3     (seven_seg3),
    .seven_seg4     (seven_seg4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full output set in one go.
  task automatic expect_out(input string tag, input logic [27:0] s, input logic act,
                            input logic bsy, input logic [7:0] cnt);
    check({tag, ".seg"}, 32'(seg), 32'(s));
    check({tag, ".act"}, 32'(drop_activated), 32'(act));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".count"}, 32'(drop_count), 32'(cnt));
  endtask

  task automatic do_reset();
    drop_en = 1'b0;
    t_act   = '0;
    t_lim   = '0;
    rst_n   = 1'b0;
    #3;
    rst_n   = 1'b1;
  endtask

  initial begin
    // Reset state.
    #12;
    expect_out("reset", Blank, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    tick();
    expect_out("idle", Blank, 1'b0, 1'b0, 8'd0);

    // 1: full drop, hold-off, back through IDLE, second drop.
    drop_en = 1'b1; t_act = 16'd10; t_lim = 16'd20;
    tick();
    expect_out("t1.drop0", Drop, 1'b1, 1'b1, 8'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_out($sformatf("t1.drop%0d", i), Drop, 1'b1, 1'b1, 8'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("t1.hold%0d", i), Dash, 1'b0, 1'b1, 8'd1);
    end
    tick();
    expect_out("t1.idle", Blank, 1'b0, 1'b0, 8'd1);
    tick();
    expect_out("t1.drop_again", Drop, 1'b1, 1'b1, 8'd2);

    // 2: inside the hysteresis band is HOT, one LSB lower drops.
    do_reset();
    drop_en = 1'b1; t_act = 16'd18; t_lim = 16'd20;
    tick();
    expect_out("t2.band", Hot, 1'b0, 1'b0, 8'd0);
    tick();
    expect_out("t2.band2", Hot, 1'b0, 1'b0, 8'd0);
    t_act = 16'd17;
    tick();
    expect_out("t2.drop", Drop, 1'b1, 1'b1, 8'd1);

    // 3: disabled monitor shows COLD, equal and above are blank.
    do_reset();
    t_act = 16'd5; t_lim = 16'd20;
    tick();
    expect_out("t3.cold", Cold, 1'b0, 1'b0, 8'd0);
    t_act = 16'd20;
    tick();
    expect_out("t3.equal", Blank, 1'b0, 1'b0, 8'd0);
    t_act = 16'd25;
    tick();
    expect_out("t3.above", Blank, 1'b0, 1'b0, 8'd0);

    // 4: abort after two DROP clocks.
    do_reset();
    drop_en = 1'b1; t_act = 16'd10; t_lim = 16'd20;
    tick();
    expect_out("t4.drop0", Drop, 1'b1, 1'b1, 8'd1);
    tick();
    expect_out("t4.drop1", Drop, 1'b1, 1'b1, 8'd1);
    drop_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("t4.hold%0d", i), Dash, 1'b0, 1'b1, 8'd1);
    end
    tick();
    expect_out("t4.idle", Blank, 1'b0, 1'b0, 8'd1);
    tick();
    expect_out("t4.cold", Cold, 1'b0, 1'b0, 8'd1);

    // 5: asynchronous reset mid-DROP.
    do_reset();
    drop_en = 1'b1; t_act = 16'd10; t_lim = 16'd20;
    tick();
    tick();
    expect_out("t5.pre", Drop, 1'b1, 1'b1, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("t5.async", Blank, 1'b0, 1'b0, 8'd0);
    tick();
    expect_out("t5.held", Blank, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    tick();
    expect_out("t5.resume", Drop, 1'b1, 1'b1, 8'd1);

    // 6: all-ones inputs must not wrap into a drop.
    do_reset();
    drop_en = 1'b1; t_act = 16'hFFFF; t_lim = 16'hFFFF;
    tick();
    expect_out("t6.nowrap", Hot, 1'b0, 1'b0, 8'd0);

    // 6: 300 back-to-back drops, 8 clocks each, saturate the counter.
    t_act = 16'd10; t_lim = 16'd20;
    for (int i = 0; i < 300 * 8; i++) tick();
    check("t6.sat", 32'(drop_count), 32'd255);
    tick();
    check("t6.sat_hold", 32'(drop_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
